// File: rtl/player_pkg.sv
// player_pkg: shared types, encodings and helpers for the auto_player song sequencer
package player_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_PAUSED} state_t;
  localparam logic [1:0] TEMPO_1X = 2'b00;
  localparam logic [1:0] TEMPO_2X = 2'b01;
  localparam logic [1:0] TEMPO_HALF = 2'b10;
  localparam logic [1:0] TEMPO_1X_ALT = 2'b11;
  localparam int NOTE_REST = 0;
  function automatic int note_end(input int nw);
    return (1 << nw) - 1;
  endfunction
  function automatic logic [31:0] led_map(input int n, input int led_w);
    return (n >= 1 && n <= led_w) ? (32'd1 << (n - 1)) : 32'd0;
  endfunction
  function automatic int entry_note(input logic [31:0] e, input int nw);
    return int'(e & ((32'd1 << nw) - 32'd1));
  endfunction
  function automatic int entry_dur(input logic [31:0] e, input int nw, input int dw);
    return int'((e >> nw) & ((32'd1 << dw) - 32'd1));
  endfunction
endpackage

// File: rtl/auto_player_if.sv
// auto_player_if: control, song image and playback outputs between library, player and drivers
interface auto_player_if #(
  parameter int SONG_LEN = 64,
  parameter int NOTE_W = 4,
  parameter int DUR_W = 3,
  parameter int LED_W = 7
);
  localparam int E = NOTE_W + DUR_W;
  localparam int PW = $clog2(SONG_LEN);
  logic [1:0] song_select;
  logic [SONG_LEN*E-1:0] song_packed;
  logic start;
  logic pause;
  logic loop_en;
  logic [1:0] tempo;
  logic [NOTE_W-1:0] note_to_play;
  logic [LED_W-1:0] led_out;
  logic playing;
  logic song_done;
  logic [PW-1:0] position;
  modport master (
    output song_select, song_packed, start, pause, loop_en, tempo,
    input note_to_play, led_out, playing, song_done, position
  );
  modport slave (
    input song_select, song_packed, start, pause, loop_en, tempo,
    output note_to_play, led_out, playing, song_done, position
  );
endinterface

// File: rtl/beat_timer.sv
// beat_timer: loadable down-counter that can be frozen and pulses expire on its last counted cycle
module beat_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_freeze,
  input  logic [CW-1:0] i_val,
  output logic          o_expire
);
  logic [CW-1:0] r_cnt;
  logic          r_run;
  assign o_expire = r_run && !i_freeze && (r_cnt == '0);
  // a load of N gives N counted cycles; frozen cycles do not count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_val - CW'(1);
      r_run <= 1'b1;
    end else if (r_run && !i_freeze) begin
      r_run <= r_cnt != '0;
      r_cnt <= (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
    end
endmodule

// File: rtl/auto_player.sv
// auto_player: steps through a packed song image with tempo, gap, pause, loop and song-change restart
module auto_player import player_pkg::*; #(
  parameter int SONG_LEN = 64,
  parameter int NOTE_W = 4,
  parameter int DUR_W = 3,
  parameter int BEAT_TICKS = 70000000,
  parameter int GAP_TICKS = 0,
  parameter int LED_W = 7
) (
  input logic clk,
  input logic rst_n,
  auto_player_if.slave bus
);
  localparam int E = NOTE_W + DUR_W;
  localparam int PW = $clog2(SONG_LEN);
  localparam longint MAXT = (longint'(1) << DUR_W) * 2 * longint'(BEAT_TICKS);
  localparam int CW = $clog2(MAXT + 1);
  state_t r_state, w_state, r_saved, w_saved;
  logic [PW-1:0] r_pos, w_pos, w_pos_nx;
  logic [NOTE_W-1:0] r_note, w_note, w_n0, w_nc, w_nn;
  logic [LED_W-1:0] r_led, w_led;
  logic r_done, w_done, r_playing;
  logic [1:0] r_sel, w_sel;
  logic [31:0] w_e0, w_ec, w_en;
  logic [CW-1:0] w_beat, w_ld_val;
  logic w_ld, w_go0, w_freeze, w_expire, w_chg, w_ok0, w_last;
  function automatic logic [CW-1:0] len_of(input logic [31:0] e, input logic [CW-1:0] b);
    return CW'(entry_dur(e, NOTE_W, DUR_W) + 1) * b - CW'(GAP_TICKS);
  endfunction
  function automatic logic [LED_W-1:0] led_of(input logic [NOTE_W-1:0] n);
    return LED_W'(led_map(int'(n), LED_W));
  endfunction
  assign w_pos_nx = r_pos + PW'(1);
  assign w_e0 = 32'(bus.song_packed[0 +: E]);
  assign w_ec = 32'(bus.song_packed[r_pos*E +: E]);
  assign w_en = 32'(bus.song_packed[w_pos_nx*E +: E]);
  assign w_n0 = NOTE_W'(entry_note(w_e0, NOTE_W));
  assign w_nc = NOTE_W'(entry_note(w_ec, NOTE_W));
  assign w_nn = NOTE_W'(entry_note(w_en, NOTE_W));
  assign w_ok0 = w_n0 != NOTE_W'(note_end(NOTE_W));
  assign w_last = (r_pos == PW'(SONG_LEN - 1)) || (w_nn == NOTE_W'(note_end(NOTE_W)));
  assign w_chg = bus.song_select != r_sel;
  assign w_beat = (bus.tempo == TEMPO_2X) ? CW'(BEAT_TICKS / 2) :
                  (bus.tempo == TEMPO_HALF) ? CW'(longint'(BEAT_TICKS) * 2) : CW'(BEAT_TICKS);
  assign w_freeze = (r_state == S_PAUSED) || (bus.pause && (r_state == S_PLAY || r_state == S_GAP));
  beat_timer #(.CW(CW)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .i_load(w_ld),
    .i_freeze(w_freeze),
    .i_val(w_ld_val),
    .o_expire(w_expire)
  );
  // next state: song change beats pause beats end-of-entry; every path to entry 0 funnels through w_go0
  always_comb begin
    w_state = r_state;
    w_saved = r_saved;
    w_pos = r_pos;
    w_note = r_note;
    w_led = r_led;
    w_done = 1'b0;
    w_ld = 1'b0;
    w_ld_val = CW'(GAP_TICKS);
    w_go0 = 1'b0;
    w_sel = (r_state == S_PAUSED && bus.pause) ? r_sel : bus.song_select;
    case (r_state)
      S_IDLE: w_go0 = bus.start;
      S_PLAY, S_GAP:
        if (w_chg) w_go0 = 1'b1;
        else if (bus.pause) begin
          w_state = S_PAUSED;
          w_saved = r_state;
          w_note = NOTE_W'(NOTE_REST);
        end else if (w_expire && r_state == S_PLAY && GAP_TICKS > 0) begin
          w_state = S_GAP;
          w_note = NOTE_W'(NOTE_REST);
          w_led = '0;
          w_ld = 1'b1;
        end else if (w_expire && w_last) begin
          w_done = 1'b1;
          w_state = S_IDLE;
          w_pos = '0;
          w_note = NOTE_W'(NOTE_REST);
          w_led = '0;
          w_go0 = bus.loop_en;
        end else if (w_expire) begin
          w_state = S_PLAY;
          w_pos = w_pos_nx;
          w_note = w_nn;
          w_led = led_of(w_nn);
          w_ld = 1'b1;
          w_ld_val = len_of(w_en, w_beat);
        end
      S_PAUSED:
        if (!bus.pause && w_chg) w_go0 = 1'b1;
        else if (!bus.pause) begin
          w_state = r_saved;
          w_note = (r_saved == S_PLAY) ? w_nc : NOTE_W'(NOTE_REST);
        end
      default: w_state = S_IDLE;
    endcase
    if (w_go0) begin
      w_pos = '0;
      w_state = w_ok0 ? S_PLAY : S_IDLE;
      w_note = w_ok0 ? w_n0 : NOTE_W'(NOTE_REST);
      w_led = w_ok0 ? led_of(w_n0) : '0;
      w_done = w_done || !w_ok0;
      w_ld = w_ok0;
      w_ld_val = len_of(w_e0, w_beat);
    end
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_saved <= S_IDLE;
      r_pos <= '0;
      r_note <= '0;
      r_led <= '0;
      r_done <= 1'b0;
      r_playing <= 1'b0;
      r_sel <= '0;
    end else begin
      r_state <= w_state;
      r_saved <= w_saved;
      r_pos <= w_pos;
      r_note <= w_note;
      r_led <= w_led;
      r_done <= w_done;
      r_playing <= w_state != S_IDLE;
      r_sel <= w_sel;
    end
  assign bus.note_to_play = r_note;
  assign bus.led_out = r_led;
  assign bus.song_done = r_done;
  assign bus.playing = r_playing;
  assign bus.position = r_pos;
endmodule

// File: tb/tb_auto_player.sv
// tb_auto_player: scoreboard bench; expected per-cycle output words are queued at stimulus time
module tb_auto_player;
  localparam int SL = 8, NW = 4, DW = 3, BT = 4, GT = 1, LW = 7, E = 7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int n1;
  logic [15:0] q[$];
  int img_n[8];
  int img_d[8];
  always #5 clk = ~clk;
  auto_player_if #(.SONG_LEN(SL), .NOTE_W(NW), .DUR_W(DW), .LED_W(LW)) bus ();
  auto_player #(
    .SONG_LEN(SL), .NOTE_W(NW), .DUR_W(DW), .BEAT_TICKS(BT), .GAP_TICKS(GT), .LED_W(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got {note,led,done,play,pos}=%h want %h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [6:0] lmap(input int n);
    logic [6:0] v;
    v = '0;
    if (n >= 1 && n <= 7) v[n-1] = 1'b1;
    return v;
  endfunction
  function automatic logic [15:0] ev(input int n, input logic [6:0] led, input bit done, input bit play, input int pos);
    return {4'(n), led, done, play, 3'(pos)};
  endfunction
  function automatic logic [15:0] obs();
    return {bus.note_to_play, bus.led_out, bus.song_done, bus.playing, bus.position};
  endfunction
  task automatic rep(input logic [15:0] v, input int k);
    repeat (k) q.push_back(v);
  endtask
  task automatic load_img();
    for (int i = 0; i < 8; i++) bus.song_packed[i*E +: E] = {3'(img_d[i]), 4'(img_n[i])};
  endtask
  task automatic push_pass(input int tmp, input bit first_done);
    int b;
    bit f;
    b = (tmp == 1) ? 2 : (tmp == 2) ? 8 : 4;
    f = first_done;
    for (int i = 0; i < 8; i++) begin
      if (img_n[i] == 15) break;
      for (int c = 0; c < (img_d[i] + 1) * b - GT; c++) begin
        q.push_back(ev(img_n[i], lmap(img_n[i]), f, 1'b1, i));
        f = 1'b0;
      end
      rep(ev(0, 7'd0, 1'b0, 1'b1, i), GT);
    end
  endtask
  task automatic drain(input string tag, input int n);
    logic [15:0] e;
    repeat (n) begin
      @(negedge clk);
      e = (q.size() > 0) ? q.pop_front() : 16'h0;
      chk(tag, obs(), e);
    end
  endtask
  task automatic go();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.loop_en = 1'b0;
    bus.tempo = 2'b00;
    bus.song_select = 2'd0;
    bus.song_packed = '0;
    img_n = '{1, 3, 5, 15, 15, 15, 15, 15};
    img_d = '{0, 1, 0, 0, 0, 0, 0, 0};
    load_img();
    @(negedge clk);
    chk("reset", obs(), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    push_pass(0, 1'b0);
    q.push_back(ev(0, 7'd0, 1'b1, 1'b0, 0));
    rep(16'h0, 2);
    go();
    drain("basic", q.size());
    bus.loop_en = 1'b1;
    push_pass(0, 1'b0);
    n1 = q.size();
    push_pass(0, 1'b1);
    q.push_back(ev(0, 7'd0, 1'b1, 1'b0, 0));
    rep(16'h0, 1);
    go();
    drain("loop", n1 + 1);
    bus.loop_en = 1'b0;
    drain("loop", q.size());
    img_n = '{2, 15, 15, 15, 15, 15, 15, 15};
    img_d = '{0, 0, 0, 0, 0, 0, 0, 0};
    load_img();
    for (int t = 1; t <= 2; t++) begin
      bus.tempo = 2'(t);
      push_pass(t, 1'b0);
      q.push_back(ev(0, 7'd0, 1'b1, 1'b0, 0));
      rep(16'h0, 1);
      go();
      drain(t == 1 ? "tempo_2x" : "tempo_half", q.size());
    end
    img_n = '{2, 4, 15, 15, 15, 15, 15, 15};
    load_img();
    bus.tempo = 2'b01;
    rep(ev(2, lmap(2), 1'b0, 1'b1, 0), 1);
    rep(ev(0, 7'd0, 1'b0, 1'b1, 0), 1);
    rep(ev(4, lmap(4), 1'b0, 1'b1, 1), 7);
    rep(ev(0, 7'd0, 1'b0, 1'b1, 1), 1);
    q.push_back(ev(0, 7'd0, 1'b1, 1'b0, 0));
    go();
    drain("tempo_next", 1);
    bus.tempo = 2'b10;
    drain("tempo_next", q.size());
    bus.tempo = 2'b00;
    img_n = '{1, 3, 5, 15, 15, 15, 15, 15};
    img_d = '{0, 1, 0, 0, 0, 0, 0, 0};
    load_img();
    rep(ev(1, lmap(1), 1'b0, 1'b1, 0), 3);
    rep(ev(0, 7'd0, 1'b0, 1'b1, 0), 1);
    rep(ev(3, lmap(3), 1'b0, 1'b1, 1), 3);
    rep(ev(0, lmap(3), 1'b0, 1'b1, 1), 10);
    rep(ev(3, lmap(3), 1'b0, 1'b1, 1), 5);
    rep(ev(0, 7'd0, 1'b0, 1'b1, 1), 1);
    rep(ev(5, lmap(5), 1'b0, 1'b1, 2), 3);
    rep(ev(0, 7'd0, 1'b0, 1'b1, 2), 1);
    q.push_back(ev(0, 7'd0, 1'b1, 1'b0, 0));
    go();
    drain("pause", 7);
    bus.pause = 1'b1;
    drain("pause", 10);
    bus.pause = 1'b0;
    drain("pause", q.size());
    push_pass(0, 1'b0);
    while (q.size() > 13) void'(q.pop_back());
    img_n = '{6, 2, 15, 15, 15, 15, 15, 15};
    img_d = '{1, 0, 0, 0, 0, 0, 0, 0};
    push_pass(0, 1'b0);
    q.push_back(ev(0, 7'd0, 1'b1, 1'b0, 0));
    rep(16'h0, 1);
    go();
    drain("song_change", 13);
    bus.song_select = 2'd1;
    load_img();
    drain("song_change", q.size());
    bus.song_select = 2'd2;
    rep(16'h0, 3);
    drain("idle_select", 3);
    img_n = '{1, 3, 5, 15, 15, 15, 15, 15};
    img_d = '{0, 1, 0, 0, 0, 0, 0, 0};
    load_img();
    push_pass(0, 1'b0);
    while (q.size() > 5) void'(q.pop_back());
    go();
    drain("pre_rst", 5);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", obs(), 16'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rep(16'h0, 2);
    drain("post_rst", 2);
    img_n = '{1, 2, 8, 0, 7, 3, 9, 4};
    img_d = '{0, 1, 0, 0, 2, 0, 0, 1};
    load_img();
    push_pass(0, 1'b0);
    q.push_back(ev(0, 7'd0, 1'b1, 1'b0, 0));
    rep(16'h0, 2);
    go();
    drain("full_len", q.size());
    img_n = '{15, 15, 15, 15, 15, 15, 15, 15};
    load_img();
    q.push_back(ev(0, 7'd0, 1'b1, 1'b0, 0));
    rep(16'h0, 2);
    go();
    drain("end_at_0", q.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/auto_player.md
Name: auto_player

Overview:
- Parametrised successor to the fixed-length auto-play block. Steps through a packed song image, one entry at a time.
- Each entry carries a note code and a per-note duration in beats.
- Adds start, pause, loop/one-shot, tempo scaling, an inter-note articulation gap and song-change restart.
- Sits between the song library (which supplies the packed image) and the buzzer/LED drivers.

Parameters:
- SONG_LEN, 64, maximum entries in the song image.
- NOTE_W, 4, note code width; code 0 = rest, all-ones = END marker.
- DUR_W, 3, duration field width; field value d means d+1 beats.
- BEAT_TICKS, 70000000, clk cycles per beat at tempo 1x.
- GAP_TICKS, 0, silent cycles at the end of each note. 0 means no gap. Must be less than BEAT_TICKS/2.
- LED_W, 7, LED output width.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- song_select, in, 2, song index, also driven to the library.
- song_packed, in, SONG_LEN*(NOTE_W+DUR_W), entry i at bits [(i+1)*E-1 : i*E], E=NOTE_W+DUR_W, layout {dur,note}.
- start, in, 1, start pulse; acted on only in IDLE.
- pause, in, 1, level; freezes playback while high.
- loop_en, in, 1, 1 = wrap to entry 0 at end of song; 0 = stop.
- tempo, in, 2, 00 = 1x, 01 = 2x (BEAT_TICKS/2), 10 = 0.5x (BEAT_TICKS*2), 11 = 1x.
- note_to_play, out, NOTE_W, note code to the buzzer.
- led_out, out, LED_W, one-hot note indicator.
- playing, out, 1, high in PLAY, GAP or PAUSED.
- song_done, out, 1, one-cycle pulse at end of song.
- position, out, $clog2(SONG_LEN), index of the current entry.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; position 0; all counters 0.
  - note_to_play 0, led_out 0, playing 0, song_done 0.
- All outputs are registered and change only on posedge clk.
- States: IDLE, PLAY, GAP, PAUSED.
- IDLE:
  - start=1 -> PLAY at the next edge, position 0.
  - note_to_play = note[0] is visible on the cycle after start.
- PLAY:
  - Beat length B is tempo-scaled and sampled when each entry is loaded. A tempo change affects the next entry, not the current one.
  - Entry duration is T = (d+1)*B cycles.
  - PLAY lasts T-GAP_TICKS cycles, then GAP for GAP_TICKS cycles. If GAP_TICKS = 0, GAP is skipped.
  - Output: note_to_play = note, led_out = map(note).
- GAP: note_to_play = 0, led_out = 0.
- End of entry (last cycle of GAP, or of PLAY when there is no gap): advance position. The song ends when either:
  - position = SONG_LEN-1, or
  - the next entry's note equals END.
- End of song:
  - song_done pulses for 1 cycle.
  - loop_en=1: position 0, stay in PLAY.
  - loop_en=0: go to IDLE, outputs 0.
- An END entry is never sounded.
- An END at entry 0 on start: single song_done pulse, return to IDLE, no note output.
- PAUSED:
  - pause=1 in PLAY or GAP -> PAUSED at the next edge.
  - Tick counter and position are frozen.
  - note_to_play = 0; led_out holds its last value.
  - pause=0 -> back to the saved state (PLAY or GAP) and resume the remaining count exactly.
  - pause is ignored in IDLE. start is ignored outside IDLE.
- song_select change:
  - The previous value is registered; any difference while playing=1 restarts at entry 0 in PLAY with counters cleared. If PAUSED, the restart applies on resume.
  - A change in IDLE has no effect.
- LED mapping: note n with 1 <= n <= LED_W sets bit n-1 only; any other code gives 0.
- Simultaneous events, by priority:
  1. reset
  2. song_select change
  3. pause
  4. end-of-entry
- Counters are wide enough for (2^DUR_W)*2*BEAT_TICKS with no overflow.

Decomposition:
- Package player_pkg:
  - state enum.
  - tempo encodings.
  - NOTE_REST and NOTE_END constants.
  - note-to-LED mapping function.
  - entry field extract helpers.
- One sub-module, beat_timer:
  - Counts tempo-scaled ticks.
  - Inputs: load, freeze.
  - Loads the cycle count T-GAP_TICKS or GAP_TICKS.
  - Issues a single-cycle expire pulse.

Test Plan (SONG_LEN=8, BEAT_TICKS=4, GAP_TICKS=1, NOTE_W=4, DUR_W=3, LED_W=7):
- Basic play. Entries {0,1},{1,3},{0,5}, rest END; loop_en=0; start pulse.
  - Expect: note 1 for 3 cycles, gap 1 cycle, note 3 for 7 cycles, gap 1, note 5 for 3, gap 1.
  - Then song_done for 1 cycle, IDLE.
  - led_out = 0000001, 0000100, 0010000 during the three notes.
- Loop. Same image with loop_en=1.
  - Expect: song_done pulse, then note 1 again on the next cycle and position = 0.
- Tempo. tempo=01 vs tempo=10 on entry {0,2}.
  - Expect: note 2 held for 1 cycle vs 7 cycles before the gap.
- Pause. Assert pause for 10 cycles, 2 cycles into note 3.
  - Expect: note_to_play 0, position and led_out held.
  - On release: note 3 resumes for the remaining 5 cycles.
- Song change. Change song_select mid-entry 2.
  - Expect: the next cycle shows entry 0 of the new image and the counters restart.
  - Assert rst_n low mid-note: all outputs 0 immediately (asynchronous).
- Full length. 8 non-END entries, loop_en=0.
  - Expect: song_done after entry 7, and position never exceeds 7.
  - An END at entry 0 gives a song_done pulse with no note output.
